// File: rtl/ca_rpt_pkg.sv
// ca_rpt_pkg: shared types for the cellular-automata report collector.
// Holds the default offset width, the FIFO record layout and the FSM states.
package ca_rpt_pkg;

    // Default and maximum symbol-offset width carried in a record.
    localparam int unsigned OFFSET_W_DEF = 16;

    // One report record: end-of-stream flag, activated-STE vector, symbol offset.
    typedef struct packed {
        logic                    eos;
        logic [7:0]              vector;
        logic [OFFSET_W_DEF-1:0] offset;
    } ca_rpt_rec_t;

    // Collector control states.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        EOS_PEND = 1'b1
    } ca_rpt_state_t;

endpackage

// File: rtl/ca_rpt_fifo.sv
// ca_rpt_fifo: synchronous show-ahead FIFO of ca_rpt_rec_t records.
// Read and write pointers carry an extra wrap bit to tell full from empty.
// A push while full is accepted only when a pop happens in the same cycle.
// The head output reads as all-zero while the FIFO is empty.
module ca_rpt_fifo
    import ca_rpt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  ca_rpt_rec_t push_rec_i,
    input  logic        pop_i,
    output ca_rpt_rec_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    ca_rpt_rec_t mem_q [DEPTH];
    logic        push_ok_s;
    logic        pop_ok_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);
    assign head_o    = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Advance pointers on accepted push/pop; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok_s) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q[AW-1:0]] <= push_rec_i;
        end
    end

endmodule

// File: rtl/ca_report_collector.sv
// ca_report_collector: aligns the CA processor's one-cycle-late report bit
// with the offset of the symbol that produced it and queues stamped records.
// An EOS marker record is appended after the last symbol of each stream.
// Optional feature macro: CA_RPT_DROP_CNT_EN adds a saturating drop counter
// and its drop_cnt output port.
module ca_report_collector
    import ca_rpt_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sym_valid,
    input  logic                sym_last,
    input  logic                rpt_bt,
    input  logic [7:0]          act_vec,
    output logic                busy,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [OFFSET_W-1:0] rec_offset,
    output logic [7:0]          rec_vector,
    output logic                rec_eos,
    output logic                overflow
`ifdef CA_RPT_DROP_CNT_EN
    ,
    output logic [7:0]          drop_cnt
`endif
);

    logic [OFFSET_W-1:0] off_q, off_d;
    logic [OFFSET_W-1:0] off_dly_q;
    logic [OFFSET_W-1:0] eos_off_q, eos_off_d;
    logic                v_dly_q;
    logic                l_dly_q;
    ca_rpt_state_t       state_q, state_d;
    logic                overflow_q, overflow_d;

    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic                can_push_s;
    logic                rpt_req_s;
    logic                drop_s;
    logic                eos_push_s;
    ca_rpt_rec_t         push_rec_s;
    ca_rpt_rec_t         head_s;

    ca_rpt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_s),
        .push_rec_i (push_rec_s),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .full_o     (full_s),
        .empty_o    (empty_s)
    );

    assign pop_s      = !empty_s && rec_ready;
    assign can_push_s = !full_s || pop_s;
    assign rpt_req_s  = v_dly_q && rpt_bt;

    // Push arbitration, drop detection and RUN/EOS_PEND next state.
    // While EOS is pending it owns the push port; a colliding report
    // (only possible from a symbol sent before busy rose) counts as dropped.
    always_comb begin
        state_d    = state_q;
        eos_off_d  = eos_off_q;
        push_s     = 1'b0;
        push_rec_s = '0;
        drop_s     = 1'b0;
        eos_push_s = 1'b0;
        case (state_q)
            RUN: begin
                if (rpt_req_s) begin
                    if (can_push_s) begin
                        push_s            = 1'b1;
                        push_rec_s.eos    = 1'b0;
                        push_rec_s.vector = act_vec;
                        push_rec_s.offset = OFFSET_W_DEF'(off_dly_q);
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    drop_s = 1'b0;
                end
                if (v_dly_q && l_dly_q) begin
                    state_d   = EOS_PEND;
                    eos_off_d = off_dly_q;
                end else begin
                    state_d = RUN;
                end
            end
            EOS_PEND: begin
                if (can_push_s) begin
                    push_s            = 1'b1;
                    push_rec_s.eos    = 1'b1;
                    push_rec_s.vector = 8'h00;
                    push_rec_s.offset = OFFSET_W_DEF'(eos_off_q);
                    eos_push_s        = 1'b1;
                    state_d           = RUN;
                end else begin
                    state_d = EOS_PEND;
                end
                if (rpt_req_s) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Symbol offset: cleared by the EOS push, else counts accepted symbols.
    always_comb begin
        off_d = off_q;
        if (eos_push_s) begin
            off_d = '0;
        end else if (sym_valid) begin
            off_d = off_q + OFFSET_W'(1);
        end else begin
            off_d = off_q;
        end
    end

    assign overflow_d = overflow_q || drop_s;

    // State, counter, alignment stage and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            off_q      <= '0;
            off_dly_q  <= '0;
            eos_off_q  <= '0;
            v_dly_q    <= 1'b0;
            l_dly_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            off_dly_q  <= off_q;
            eos_off_q  <= eos_off_d;
            v_dly_q    <= sym_valid;
            l_dly_q    <= sym_valid && sym_last;
            overflow_q <= overflow_d;
        end
    end

`ifdef CA_RPT_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped reports.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign busy       = (state_q == EOS_PEND);
    assign rec_valid  = !empty_s;
    assign rec_offset = head_s.offset[OFFSET_W-1:0];
    assign rec_vector = head_s.vector;
    assign rec_eos    = head_s.eos;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ca_report_collector.sv
// Directed self-checking bench for ca_report_collector.
// A second instance with OFFSET_W=4 shares the stimulus to exercise offset wrap.
module tb_ca_report_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sym_valid = 1'b0;
    logic        sym_last = 1'b0;
    logic        rpt_bt = 1'b0;
    logic [7:0]  act_vec = 8'h00;
    logic        rec_ready = 1'b0;

    logic        busy, rec_valid, rec_eos, overflow;
    logic [15:0] rec_offset;
    logic [7:0]  rec_vector;
    logic        w4_busy, w4_rec_valid, w4_rec_eos, w4_overflow;
    logic [3:0]  w4_rec_offset;
    logic [7:0]  w4_rec_vector;
`ifdef CA_RPT_DROP_CNT_EN
    logic [7:0]  drop_cnt, w4_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ca_report_collector #(.DEPTH(8), .OFFSET_W(16)) u_dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_last(sym_last),
        .rpt_bt(rpt_bt), .act_vec(act_vec), .busy(busy), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_offset(rec_offset), .rec_vector(rec_vector),
        .rec_eos(rec_eos), .overflow(overflow)
`ifdef CA_RPT_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    ca_report_collector #(.DEPTH(8), .OFFSET_W(4)) u_dut_w4 (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_last(sym_last),
        .rpt_bt(rpt_bt), .act_vec(act_vec), .busy(w4_busy), .rec_valid(w4_rec_valid),
        .rec_ready(rec_ready), .rec_offset(w4_rec_offset), .rec_vector(w4_rec_vector),
        .rec_eos(w4_rec_eos), .overflow(w4_overflow)
`ifdef CA_RPT_DROP_CNT_EN
        , .drop_cnt(w4_drop_cnt)
`endif
    );

    // Upstream must not present a symbol while the collector is busy.
    always @(negedge clk) begin
        if (!rst && sym_valid && busy) begin
            errors++;
            $display("FAIL sym_valid_while_busy: sym_valid=1 busy=1, required sym_valid=0");
        end
    end

    task automatic cyc(input logic v, input logic last, input logic rpt,
                       input logic [7:0] vec, input logic rdy);
        sym_valid = v;
        sym_last  = last;
        rpt_bt    = rpt;
        act_vec   = vec;
        rec_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rec_valid, rec_offset, rec_vector, rec_eos, overflow, busy} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rec_valid, rec_offset, rec_vector, rec_eos, overflow, busy});
        end
        checks++;
        if ({w4_rec_valid, w4_rec_offset, w4_rec_vector, w4_rec_eos, w4_overflow, w4_busy} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs_w4: got %h required 0",
                     {w4_rec_valid, w4_rec_offset, w4_rec_vector, w4_rec_eos, w4_overflow, w4_busy});
        end
`ifdef CA_RPT_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_single_report();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: rec_valid=%b required 0", rec_valid);
        end
        cyc(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
        checks++;
        if ({rec_valid, rec_eos, rec_offset, rec_vector} !== {1'b1, 1'b0, 16'd2, 8'hA5}) begin
            errors++;
            $display("FAIL single_record: got v=%b eos=%b off=%0d vec=%h required v=1 eos=0 off=2 vec=a5",
                     rec_valid, rec_eos, rec_offset, rec_vector);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: rec_valid=%b required 0", rec_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            cyc(i < 10, 1'b0, i > 0, 8'(8'h0F + i), 1'b0);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: overflow=%b required 1", overflow);
        end
`ifdef CA_RPT_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ovf_drop_cnt: got %0d required 2", drop_cnt);
        end
`endif
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({rec_valid, rec_eos, rec_offset, rec_vector} !== {1'b1, 1'b0, 16'(k), 8'(8'h10 + k)}) begin
                errors++;
                $display("FAIL ovf_drain_%0d: got v=%b eos=%b off=%0d vec=%h required v=1 eos=0 off=%0d vec=%h",
                         k, rec_valid, rec_eos, rec_offset, rec_vector, k, 8'(8'h10 + k));
            end
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: rec_valid=%b required 0", rec_valid);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
        checks++;
        if ({busy, rec_valid, overflow} !== 3'b111) begin
            errors++;
            $display("FAIL mid_before: busy/valid/ovf=%b required 111", {busy, rec_valid, overflow});
        end
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        checks++;
        if ({busy, rec_valid, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL mid_after_rst: busy/valid/ovf=%b required 000", {busy, rec_valid, overflow});
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
        checks++;
        if ({rec_valid, rec_eos, rec_offset, rec_vector} !== {1'b1, 1'b0, 16'd0, 8'h44}) begin
            errors++;
            $display("FAIL mid_next_report: got v=%b eos=%b off=%0d vec=%h required v=1 eos=0 off=0 vec=44",
                     rec_valid, rec_eos, rec_offset, rec_vector);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i <= 9; i++) begin
            cyc(i < 9, 1'b0, i > 0, 8'(8'h1F + i), i == 9);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_ovf: overflow=%b required 0", overflow);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({rec_valid, rec_eos, rec_offset, rec_vector} !== {1'b1, 1'b0, 16'(k), 8'(8'h20 + k)}) begin
                errors++;
                $display("FAIL fullpop_drain_%0d: got v=%b eos=%b off=%0d vec=%h required v=1 eos=0 off=%0d vec=%h",
                         k, rec_valid, rec_eos, rec_offset, rec_vector, k, 8'(8'h20 + k));
            end
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_empty: rec_valid=%b required 0", rec_valid);
        end
    endtask

    task automatic test_eos();
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL eos_busy_early: busy=%b required 0", busy);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL eos_busy_pend: busy=%b required 1", busy);
        end
        checks++;
        if ({rec_valid, rec_eos, rec_offset, rec_vector} !== {1'b1, 1'b0, 16'd2, 8'h3C}) begin
            errors++;
            $display("FAIL eos_report_rec: got v=%b eos=%b off=%0d vec=%h required v=1 eos=0 off=2 vec=3c",
                     rec_valid, rec_eos, rec_offset, rec_vector);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL eos_busy_release: busy=%b required 0", busy);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({rec_valid, rec_eos, rec_offset, rec_vector} !== {1'b1, 1'b1, 16'd2, 8'h00}) begin
            errors++;
            $display("FAIL eos_marker_rec: got v=%b eos=%b off=%0d vec=%h required v=1 eos=1 off=2 vec=00",
                     rec_valid, rec_eos, rec_offset, rec_vector);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++;
            $display("FAIL eos_empty: rec_valid=%b required 0", rec_valid);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        checks++;
        if ({rec_valid, rec_eos, rec_offset, rec_vector} !== {1'b1, 1'b0, 16'd0, 8'h77}) begin
            errors++;
            $display("FAIL eos_next_stream: got v=%b eos=%b off=%0d vec=%h required v=1 eos=0 off=0 vec=77",
                     rec_valid, rec_eos, rec_offset, rec_vector);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i <= 17; i++) begin
            cyc(i < 17, 1'b0, i >= 16, 8'(8'hE0 + i), 1'b0);
        end
        checks++;
        if ({w4_rec_valid, w4_rec_offset, w4_rec_vector} !== {1'b1, 4'd15, 8'hF0}) begin
            errors++;
            $display("FAIL wrap_w4_15: got v=%b off=%0d vec=%h required v=1 off=15 vec=f0",
                     w4_rec_valid, w4_rec_offset, w4_rec_vector);
        end
        checks++;
        if ({rec_valid, rec_offset} !== {1'b1, 16'd15}) begin
            errors++;
            $display("FAIL wrap_w16_15: got v=%b off=%0d required v=1 off=15", rec_valid, rec_offset);
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({w4_rec_valid, w4_rec_eos, w4_rec_offset, w4_rec_vector} !== {1'b1, 1'b0, 4'd0, 8'hF1}) begin
            errors++;
            $display("FAIL wrap_w4_0: got v=%b eos=%b off=%0d vec=%h required v=1 eos=0 off=0 vec=f1",
                     w4_rec_valid, w4_rec_eos, w4_rec_offset, w4_rec_vector);
        end
        checks++;
        if ({rec_valid, rec_offset} !== {1'b1, 16'd16}) begin
            errors++;
            $display("FAIL wrap_w16_16: got v=%b off=%0d required v=1 off=16", rec_valid, rec_offset);
        end
    endtask

    initial begin
        test_reset();
        test_single_report();
        test_overflow();
        test_reset_mid();
        test_full_pop();
        test_eos();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
